// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit instruction per line.
//
// Sits between the instruction fetcher (upstream) and the memory
// controller's instruction channel (downstream). A hit answers one cycle
// after the request. A miss sends a one-cycle fetch pulse downstream, waits
// for the completion pulse, fills the line and forwards the instruction.
// A ROB mispredict abandons any outstanding miss.
//
// Optional feature macro: ICACHE_STATS_EN adds hit/miss counters
// (oHitCnt, oMissCnt). With the macro undefined those ports do not exist.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   en                global ready; when low every register holds
//   iIF_En, iIF_Pc    fetch request pulse and byte address
//   oIF_En, oIF_Ins   instruction valid pulse and instruction
//   oIF_Busy          high while a miss is outstanding (state exposure)
//   oMC_En, oMC_Pc    fetch pulse and word-aligned address to memory
//   iMC_En, iMC_Ins   fetch-done pulse and instruction from memory
//   iROB_Mp           mispredict flush, highest priority
//   oHitCnt, oMissCnt request statistics (ICACHE_STATS_EN only)
//
// Handshake: all upstream/downstream signals are single-cycle pulses
// sampled on posedge clk with en = 1; there is no back-pressure other than
// oIF_Busy, during which the fetcher must not issue requests.
module icache #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              iIF_En,
   input  logic [ADDR_W-1:0] iIF_Pc,
   output logic              oIF_En,
   output logic [31:0]       oIF_Ins,
   output logic              oIF_Busy,
   output logic              oMC_En,
   output logic [ADDR_W-1:0] oMC_Pc,
   input  logic              iMC_En,
   input  logic [31:0]       iMC_Ins,
`ifdef ICACHE_STATS_EN
   output logic [31:0]       oHitCnt,
   output logic [31:0]       oMissCnt,
`endif
   input  logic              iROB_Mp
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W - 2;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   state_t state, state_d;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       data_q [LINES];

   logic [ADDR_W-1:0] pc_q, pc_d;

   logic              if_en_d;
   logic [31:0]       if_ins_d;
   logic              mc_en_d;
   logic [ADDR_W-1:0] mc_pc_d;
   logic              fill_we;
   logic              hit_acc;
   logic              miss_acc;

   logic [INDEX_W-1:0] idx_req, idx_fill;
   logic [TAG_W-1:0]   tag_req, tag_fill;
   logic               hit;

   // Byte offset bits never select anything in a one-word line.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{iIF_Pc[1:0], pc_q[1:0]};

   assign idx_req  = iIF_Pc[INDEX_W+1:2];
   assign tag_req  = iIF_Pc[ADDR_W-1:INDEX_W+2];
   // The fill targets the line of the latched miss address, not the
   // address currently on iIF_Pc.
   assign idx_fill = pc_q[INDEX_W+1:2];
   assign tag_fill = pc_q[ADDR_W-1:INDEX_W+2];
   assign hit      = valid_q[idx_req] && (tag_q[idx_req] == tag_req);

   assign oIF_Busy = (state != IDLE);

   always_comb begin
      state_d  = state;
      pc_d     = pc_q;
      if_en_d  = 1'b0;
      if_ins_d = oIF_Ins;
      mc_en_d  = 1'b0;
      mc_pc_d  = oMC_Pc;
      fill_we  = 1'b0;
      hit_acc  = 1'b0;
      miss_acc = 1'b0;
      if (iROB_Mp) begin
         state_d = IDLE;
         // A response coinciding with the flush is still correct data for
         // the latched address, so keep it; just do not forward it.
         if (state == MISS && iMC_En) fill_we = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (iIF_En) begin
                  pc_d = iIF_Pc;
                  if (hit) begin
                     hit_acc  = 1'b1;
                     if_en_d  = 1'b1;
                     if_ins_d = data_q[idx_req];
                  end else begin
                     miss_acc = 1'b1;
                     mc_en_d  = 1'b1;
                     mc_pc_d  = {iIF_Pc[ADDR_W-1:2], 2'b00};
                     state_d  = MISS;
                  end
               end
            end
            MISS: begin
               if (iMC_En) begin
                  fill_we  = 1'b1;
                  if_en_d  = 1'b1;
                  if_ins_d = iMC_Ins;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid_q <= '0;
         pc_q    <= '0;
         oIF_En  <= 1'b0;
         oIF_Ins <= '0;
         oMC_En  <= 1'b0;
         oMC_Pc  <= '0;
      end else if (en) begin
         state   <= state_d;
         pc_q    <= pc_d;
         oIF_En  <= if_en_d;
         oIF_Ins <= if_ins_d;
         oMC_En  <= mc_en_d;
         oMC_Pc  <= mc_pc_d;
         if (fill_we) valid_q[idx_fill] <= 1'b1;
      end
   end

   // Tag and data need no reset: valid_q alone decides whether they count.
   always_ff @(posedge clk) begin
      if (en && fill_we) begin
         tag_q[idx_fill]  <= tag_fill;
         data_q[idx_fill] <= iMC_Ins;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         oHitCnt  <= '0;
         oMissCnt <= '0;
      end else if (en) begin
         if (hit_acc)  oHitCnt  <= oHitCnt + 32'd1;
         if (miss_acc) oMissCnt <= oMissCnt + 32'd1;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = hit_acc ^ miss_acc;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache.
//
// A transaction-level model (word-address map per index, pending-miss flag)
// predicts outputs each cycle; a compare process checks them on every
// negedge. Directed scenarios add literal expectations that pin the model.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        iIF_En;
   logic [31:0] iIF_Pc;
   logic        oIF_En;
   logic [31:0] oIF_Ins;
   logic        oIF_Busy;
   logic        oMC_En;
   logic [31:0] oMC_Pc;
   logic        iMC_En;
   logic [31:0] iMC_Ins;
   logic        iROB_Mp;
`ifdef ICACHE_STATS_EN
   logic [31:0] oHitCnt;
   logic [31:0] oMissCnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   icache #(.ADDR_W(32), .INDEX_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .iIF_En   (iIF_En),
      .iIF_Pc   (iIF_Pc),
      .oIF_En   (oIF_En),
      .oIF_Ins  (oIF_Ins),
      .oIF_Busy (oIF_Busy),
      .oMC_En   (oMC_En),
      .oMC_Pc   (oMC_Pc),
      .iMC_En   (iMC_En),
      .iMC_Ins  (iMC_Ins),
`ifdef ICACHE_STATS_EN
      .oHitCnt  (oHitCnt),
      .oMissCnt (oMissCnt),
`endif
      .iROB_Mp  (iROB_Mp)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [29:0] line_waddr [int];
   logic [31:0] line_data  [int];
   bit          model_live = 1'b0;
   bit          m_busy;
   logic [31:0] m_pc;
   bit          exp_if_en, exp_mc_en;
   logic [31:0] exp_if_ins, exp_mc_pc;
   logic [31:0] m_hits, m_misses;

   task automatic model_fill(input logic [31:0] pc, input logic [31:0] d);
      line_waddr[int'(pc[9:2])] = pc[31:2];
      line_data[int'(pc[9:2])]  = d;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         line_waddr.delete();
         line_data.delete();
         m_busy = 0; m_pc = '0;
         exp_if_en = 0; exp_mc_en = 0; exp_if_ins = '0; exp_mc_pc = '0;
         m_hits = '0; m_misses = '0;
         model_live = 1'b1;
      end else if (en) begin
         exp_if_en = 0;
         exp_mc_en = 0;
         if (iROB_Mp) begin
            if (m_busy && iMC_En) model_fill(m_pc, iMC_Ins);
            m_busy = 0;
         end else if (!m_busy) begin
            if (iIF_En) begin
               m_pc = iIF_Pc;
               if (line_waddr.exists(int'(iIF_Pc[9:2])) &&
                   line_waddr[int'(iIF_Pc[9:2])] == iIF_Pc[31:2]) begin
                  exp_if_en  = 1;
                  exp_if_ins = line_data[int'(iIF_Pc[9:2])];
                  m_hits++;
               end else begin
                  exp_mc_en = 1;
                  exp_mc_pc = iIF_Pc & 32'hFFFF_FFFC;
                  m_busy    = 1;
                  m_misses++;
               end
            end
         end else if (iMC_En) begin
            model_fill(m_pc, iMC_Ins);
            exp_if_en  = 1;
            exp_if_ins = iMC_Ins;
            m_busy     = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("model_busy", {31'd0, oIF_Busy}, {31'd0, m_busy});
         check("model_if_en", {31'd0, oIF_En}, {31'd0, exp_if_en});
         if (exp_if_en) check("model_if_ins", oIF_Ins, exp_if_ins);
         check("model_mc_en", {31'd0, oMC_En}, {31'd0, exp_mc_en});
         if (exp_mc_en) check("model_mc_pc", oMC_Pc, exp_mc_pc);
`ifdef ICACHE_STATS_EN
         check("model_hit_cnt", oHitCnt, m_hits);
         check("model_miss_cnt", oMissCnt, m_misses);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Leaves the bench one cycle after the request was sampled.
   task automatic request(input logic [31:0] pc);
      iIF_En = 1'b1;
      iIF_Pc = pc;
      tick();
      iIF_En = 1'b0;
   endtask

   // Called in the cycle oMC_En is high; answers wait_cycles later and
   // checks the forwarded instruction one cycle after iMC_En.
   task automatic mc_respond(input int wait_cycles, input logic [31:0] d, input string name);
      repeat (wait_cycles) tick();
      iMC_En  = 1'b1;
      iMC_Ins = d;
      tick();
      iMC_En  = 1'b0;
      check({name, "_if_en"}, {31'd0, oIF_En}, 32'd1);
      check({name, "_if_ins"}, oIF_Ins, d);
   endtask

   task automatic expect_miss(input logic [31:0] pc, input string name);
      check({name, "_mc_en"}, {31'd0, oMC_En}, 32'd1);
      check({name, "_mc_pc"}, oMC_Pc, pc);
      check({name, "_busy"}, {31'd0, oIF_Busy}, 32'd1);
   endtask

   task automatic expect_hit(input logic [31:0] d, input string name);
      check({name, "_if_en"}, {31'd0, oIF_En}, 32'd1);
      check({name, "_if_ins"}, oIF_Ins, d);
      check({name, "_no_mc"}, {31'd0, oMC_En}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; iIF_En = 1'b0; iIF_Pc = '0;
      iMC_En = 1'b0; iMC_Ins = '0; iROB_Mp = 1'b0;
      repeat (3) tick();
      check("reset_if_en", {31'd0, oIF_En}, 32'd0);
      check("reset_if_ins", oIF_Ins, 32'd0);
      check("reset_mc_en", {31'd0, oMC_En}, 32'd0);
      check("reset_mc_pc", oMC_Pc, 32'd0);
      check("reset_busy", {31'd0, oIF_Busy}, 32'd0);
      rst = 1'b0;
      tick();

      // Cold miss, response four cycles after oMC_En.
      request(32'h0000_0104);
      expect_miss(32'h0000_0104, "cold");
      mc_respond(4, 32'h00A0_0093, "cold_fill");
      tick();
      check("cold_busy_after", {31'd0, oIF_Busy}, 32'd0);

      // Hit on the same address.
      request(32'h0000_0104);
      expect_hit(32'h00A0_0093, "hit");
      tick();

      // Conflict on index 0x41, then the evicted address misses again.
      request(32'h0000_0504);
      expect_miss(32'h0000_0504, "conflict");
      mc_respond(2, 32'hDEAD_BEEF, "conflict_fill");
      request(32'h0000_0104);
      expect_miss(32'h0000_0104, "evicted");
      mc_respond(1, 32'h00A0_0093, "evicted_fill");

      // Mispredict two cycles after oMC_En, memory never answers.
      request(32'h0000_0200);
      expect_miss(32'h0000_0200, "mp");
      tick();
      tick();
      iROB_Mp = 1'b1;
      tick();
      iROB_Mp = 1'b0;
      check("mp_busy_drop", {31'd0, oIF_Busy}, 32'd0);
      check("mp_no_if_en", {31'd0, oIF_En}, 32'd0);
      request(32'h0000_0300);
      expect_miss(32'h0000_0300, "after_mp");
      mc_respond(1, 32'h1111_1111, "after_mp_fill");

      // Flush coincident with fill: filled but not forwarded.
      request(32'h0000_0208);
      expect_miss(32'h0000_0208, "coinc");
      tick();
      iMC_En = 1'b1; iMC_Ins = 32'h1234_5678; iROB_Mp = 1'b1;
      tick();
      iMC_En = 1'b0; iROB_Mp = 1'b0;
      check("coinc_no_if_en", {31'd0, oIF_En}, 32'd0);
      check("coinc_busy", {31'd0, oIF_Busy}, 32'd0);
      request(32'h0000_0208);
      expect_hit(32'h1234_5678, "coinc_hit");
      tick();

      // Late response in IDLE after a flush: ignored, line stays invalid.
      request(32'h0000_0400);
      expect_miss(32'h0000_0400, "late");
      iROB_Mp = 1'b1;
      tick();
      iROB_Mp = 1'b0;
      iMC_En = 1'b1; iMC_Ins = 32'h4444_4444;
      tick();
      iMC_En = 1'b0;
      check("late_no_if_en", {31'd0, oIF_En}, 32'd0);
      request(32'h0000_0400);
      expect_miss(32'h0000_0400, "late_refetch");
      mc_respond(1, 32'h4040_4040, "late_fill");

      // Stall mid-miss with iMC_En held but not sampled.
      request(32'h0000_0600);
      expect_miss(32'h0000_0600, "stall");
      tick();
      en = 1'b0; iMC_En = 1'b1; iMC_Ins = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_busy", {31'd0, oIF_Busy}, 32'd1);
         check("stall_if_en", {31'd0, oIF_En}, 32'd0);
         check("stall_mc_en", {31'd0, oMC_En}, 32'd0);
      end
      en = 1'b1;
      tick();
      iMC_En = 1'b0;
      check("stall_if_en_after", {31'd0, oIF_En}, 32'd1);
      check("stall_if_ins_after", oIF_Ins, 32'hCAFE_F00D);
      // Request right after oIF_En sees the new line.
      request(32'h0000_0600);
      expect_hit(32'hCAFE_F00D, "hit_after_fill");
      tick();
`ifdef ICACHE_STATS_EN
      check("stats_hits", oHitCnt, 32'd3);
      check("stats_misses", oMissCnt, 32'd9);
`endif

      // Reset mid-miss invalidates everything.
      request(32'h0000_0700);
      expect_miss(32'h0000_0700, "rst_mid");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", {31'd0, oIF_Busy}, 32'd0);
      check("rst_mid_mc_en", {31'd0, oMC_En}, 32'd0);
      request(32'h0000_0104);
      expect_miss(32'h0000_0104, "post_rst");
      mc_respond(2, 32'h00A0_0093, "post_rst_fill");
      tick();
`ifdef ICACHE_STATS_EN
      check("stats_hits_post_rst", oHitCnt, 32'd0);
      check("stats_misses_post_rst", oMissCnt, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
